// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// default SAD hold length and a saturating counter helper.
package hazard_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SAD_BUSY    = 2'd1,
      SAD_RELEASE = 2'd2
   } hsc_state_e;

   localparam int unsigned SAD_STALL_CYCLES_DEFAULT = 32'd3;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module load_use_detect (
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_uses_rt,
   output logic       load_hit
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (EX_rt == ID_rs);
   assign w_rt_match = ID_uses_rt & (EX_rt == ID_rt);
   // r0 is hardwired zero, so a load into it never creates a dependency
   assign load_hit   = EX_MemRead & (EX_rt != 5'd0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles plus a fixed-length hold for
// SAD-class instructions, with a saturating count of stalled cycles.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned SAD_STALL_CYCLES = SAD_STALL_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_uses_rt,
   input  logic        ID_sad_op,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        flush,
   output logic        stall,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        sad_busy,
   output logic [15:0] stall_count
);

   localparam logic [3:0] CNT_LOAD = 4'(SAD_STALL_CYCLES - 32'd1);

   hsc_state_e  r_state;
   hsc_state_e  w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [15:0] r_stall_count;
   logic        w_load_hit;
   logic        w_stall;

   load_use_detect u_load_use_detect (
      .EX_MemRead (EX_MemRead),
      .EX_rt      (EX_rt),
      .ID_rs      (ID_rs),
      .ID_rt      (ID_rt),
      .ID_uses_rt (ID_uses_rt),
      .load_hit   (w_load_hit)
   );

   // Stall decision: flush and reset win, then load-use, then SAD sequencing
   always_comb begin
      w_stall = 1'b0;
      if (rst || flush) begin
         w_stall = 1'b0;
      end else if (w_load_hit) begin
         w_stall = 1'b1;
      end else if (r_state == SAD_BUSY) begin
         w_stall = 1'b1;
      end else if ((r_state == IDLE) && ID_sad_op) begin
         w_stall = 1'b1;
      end else begin
         w_stall = 1'b0;
      end
   end

   // Next state: the IDLE cycle that accepts a SAD op already stalls, so
   // SAD_BUSY only has to cover the remaining SAD_STALL_CYCLES-1 cycles
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (flush) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ID_sad_op && !w_load_hit) begin
                  if (SAD_STALL_CYCLES == 32'd1) begin
                     w_state_nxt = SAD_RELEASE;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_state_nxt = SAD_BUSY;
                     w_cnt_nxt   = CNT_LOAD;
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = 4'd0;
               end
            end
            SAD_BUSY: begin
               if (r_cnt > 4'd1) begin
                  w_state_nxt = SAD_BUSY;
                  w_cnt_nxt   = r_cnt - 4'd1;
               end else begin
                  w_state_nxt = SAD_RELEASE;
                  w_cnt_nxt   = 4'd0;
               end
            end
            SAD_RELEASE: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 4'd0;
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // State, hold counter and saturating stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= 4'd0;
         r_stall_count <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_stall) begin
            r_stall_count <= sat_inc16(r_stall_count);
         end else begin
            r_stall_count <= r_stall_count;
         end
      end
   end

   assign stall       = w_stall;
   assign PCWrite     = ~w_stall;
   assign IF_ID_Write = ~w_stall;
   assign sad_busy    = (r_state == SAD_BUSY) & ~rst;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a behavioural reference model
// pushes expected outputs per driven cycle; they are popped and compared mid-cycle.
module tb_hazard_stall_ctrl;

   localparam int P = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_uses_rt;
   logic        ID_sad_op;
   logic        EX_MemRead;
   logic [4:0]  EX_rt;
   logic        flush;
   logic        stall;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        sad_busy;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   logic [19:0] exp_q[$];
   string       tag_q[$];

   // reference model: remaining SAD_BUSY cycles, pending release, stall tally
   int m_busy_left = 0;
   bit m_release   = 1'b0;
   int m_count     = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.SAD_STALL_CYCLES(P)) dut (
      .clk         (clk),
      .rst         (rst),
      .ID_rs       (ID_rs),
      .ID_rt       (ID_rt),
      .ID_uses_rt  (ID_uses_rt),
      .ID_sad_op   (ID_sad_op),
      .EX_MemRead  (EX_MemRead),
      .EX_rt       (EX_rt),
      .flush       (flush),
      .stall       (stall),
      .PCWrite     (PCWrite),
      .IF_ID_Write (IF_ID_Write),
      .sad_busy    (sad_busy),
      .stall_count (stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit r, input bit fl, input bit sad,
                       input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input bit urt);
      bit          lh;
      bit          in_busy;
      bit          e_stall;
      logic [19:0] e;
      logic [19:0] got;
      string       t;
      rst = r; flush = fl; ID_sad_op = sad; EX_MemRead = mr;
      EX_rt = ert; ID_rs = rs; ID_rt = rt; ID_uses_rt = urt;
      lh      = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
      in_busy = (m_busy_left > 0);
      if (r || fl) e_stall = 1'b0;
      else e_stall = lh || in_busy || (!in_busy && !m_release && sad);
      e = {e_stall, !e_stall, !e_stall, (in_busy && !r), 16'(m_count)};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      if (r) begin
         m_busy_left = 0; m_release = 1'b0; m_count = 0;
      end else begin
         if (fl) begin
            m_busy_left = 0; m_release = 1'b0;
         end else if (in_busy) begin
            m_busy_left--;
            if (m_busy_left == 0) m_release = 1'b1;
         end else if (m_release) begin
            m_release = 1'b0;
         end else if (sad && !lh) begin
            if (P == 1) m_release = 1'b1;
            else m_busy_left = P - 1;
         end
         if (e_stall && (m_count < 65535)) m_count++;
      end
      @(negedge clk);
      got = {stall, PCWrite, IF_ID_Write, sad_busy, stall_count};
      chk(tag_q.pop_front(), {12'd0, got}, {12'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ID_sad_op = 1'b0; EX_MemRead = 1'b0;
      EX_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
      @(posedge clk);
      #1;
      // reset: outputs forced idle even with hazard inputs present
      step("rst_q",     1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
      step("rst_q2",    1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step("idle",      0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // single load-use bubble on rs
      step("lh_rs",     0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      step("lh_after",  0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0);
      // r0 never hazards; rt only counts when used
      step("lh_r0",     0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
      step("lh_rt",     0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
      step("lh_rt_nu",  0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
      step("lh_noload", 0, 0, 0, 0, 5'd7, 5'd7, 5'd7, 1);
      // SAD hold, then back-to-back second SAD
      for (int i = 0; i < 8; i++) step("sad_b2b", 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 1);
      step("sad_end",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // flush in second SAD_BUSY cycle
      step("fl_idle",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("fl_busy1",  0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("fl_busy2",  0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0);
      step("fl_after",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // SAD op arriving with a load hit: one bubble then the full sequence
      step("sadlh_0",   0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0);
      for (int i = 0; i < 4; i++) step("sadlh_seq", 0, 0, 1, 0, 5'd4, 5'd4, 5'd0, 0);
      step("sadlh_end", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // load hit during SAD_RELEASE still stalls
      step("rel_0",     0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rel_1",     0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rel_2",     0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rel_lh",    0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0);
      step("rel_end",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // saturation of the stall counter
      for (int i = 0; i < 70000; i++) step("sat", 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      step("sat_hold",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      // reset abandons a SAD sequence
      step("rs_sad0",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rs_sad1",   0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rs_mid",    1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rs_after",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step("rs_after2", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      chk("sat_direct", 32'(m_count), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
